// File: rtl/turfio_hub_ctrl_if.sv
// turfio_hub_ctrl_if
// WISHBONE classic slave bundle for the TURFIO hub.
//   wb_cyc_i/wb_stb_i/wb_we_i : bus cycle, strobe, write enable (master -> hub)
//   wb_adr_i                  : byte address, ADR_BITS wide
//   wb_dat_i/wb_sel_i         : write data and byte selects
//   wb_dat_o                  : read data, valid only while a response is driven
//   wb_ack_o/wb_err_o/wb_rty_o: one-cycle response pulses (hub -> master)
// Handshake: a request is valid while cyc&stb are high; the hub answers with
// exactly one single-cycle ack, err or rty pulse. The master holds the request
// stable until that pulse and then drops stb. Dropping cyc abandons the request.
interface turfio_hub_ctrl_if #(
  parameter int ADR_BITS = 15
);
  logic                wb_cyc_i;
  logic                wb_stb_i;
  logic                wb_we_i;
  logic [ADR_BITS-1:0] wb_adr_i;
  logic [31:0]         wb_dat_i;
  logic [3:0]          wb_sel_i;
  logic [31:0]         wb_dat_o;
  logic                wb_ack_o;
  logic                wb_err_o;
  logic                wb_rty_o;

  modport master (
    output wb_cyc_i, wb_stb_i, wb_we_i, wb_adr_i, wb_dat_i, wb_sel_i,
    input  wb_dat_o, wb_ack_o, wb_err_o, wb_rty_o
  );

  modport slave (
    input  wb_cyc_i, wb_stb_i, wb_we_i, wb_adr_i, wb_dat_i, wb_sel_i,
    output wb_dat_o, wb_ack_o, wb_err_o, wb_rty_o
  );
endinterface

// File: rtl/turfio_hub_ctrl.sv
// turfio_hub_ctrl
// WISHBONE hub plus control/status registers for the TURFIO links and banks.
// Ports:
//   clk_i, rst_i        : system clock, asynchronous active-high reset
//   wb                  : WISHBONE slave bundle (turfio_hub_ctrl_if.slave)
//   lnk_*_o / lnk_*_i   : per-link WISHBONE master side (strobes one-hot per link,
//                         address/data/sel broadcast)
//   mmcm_locked_i, idelay_rdy_i : asynchronous per-bank status
//   mmcm_rst_o, idelay_rst_o, bank_rst_o : per-bank resets
//   dbg_state           : current hub FSM state
// Address bit ADR_BITS-1 picks local registers (0) or a link window (1).
module turfio_hub_ctrl #(
  parameter int NUM_IF        = 4,
  parameter int ADR_BITS      = 15,
  parameter int NUM_BANK      = 2,
  parameter int TIMEOUT       = 255,
  parameter int RST_PULSE_LEN = 16,
  localparam int NUM_IF_BITS  = (NUM_IF > 1) ? $clog2(NUM_IF) : 1,
  localparam int SUB_BITS     = ADR_BITS - 1 - NUM_IF_BITS
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  turfio_hub_ctrl_if.slave           wb,
  output logic [NUM_IF-1:0]          lnk_cyc_o,
  output logic [NUM_IF-1:0]          lnk_stb_o,
  output logic [NUM_IF-1:0]          lnk_we_o,
  output logic [NUM_IF*SUB_BITS-1:0] lnk_adr_o,
  output logic [31:0]                lnk_dat_o,
  output logic [3:0]                 lnk_sel_o,
  input  logic [NUM_IF*32-1:0]       lnk_dat_i,
  input  logic [NUM_IF-1:0]          lnk_ack_i,
  input  logic [NUM_IF-1:0]          lnk_err_i,
  input  logic [NUM_IF-1:0]          lnk_rty_i,
  input  logic [NUM_BANK-1:0]        mmcm_locked_i,
  input  logic [NUM_BANK-1:0]        idelay_rdy_i,
  output logic [NUM_BANK-1:0]        mmcm_rst_o,
  output logic [NUM_BANK-1:0]        idelay_rst_o,
  output logic [NUM_BANK-1:0]        bank_rst_o,
  output logic [1:0]                 dbg_state
);
  typedef enum logic [1:0] {S_IDLE, S_LRESP, S_REMOTE, S_RRESP} state_t;
  state_t state, state_nxt;

  // Request decode
  logic                   req, is_link, lwr;
  logic [NUM_IF_BITS-1:0] dec_idx;
  logic [1:0]             reg_idx;
  assign req     = wb.wb_cyc_i & wb.wb_stb_i;
  assign is_link = wb.wb_adr_i[ADR_BITS-1];
  assign dec_idx = (NUM_IF == 1) ? '0 : wb.wb_adr_i[ADR_BITS-2 -: NUM_IF_BITS];
  assign reg_idx = wb.wb_adr_i[3:2];
  assign lwr     = (state == S_IDLE) && req && !is_link && wb.wb_we_i;

  // Latched link request and response
  logic [NUM_IF_BITS-1:0] idx_q;
  logic [SUB_BITS-1:0]    adr_q;
  logic                   we_q;
  logic [3:0]             sel_q;
  logic [31:0]            wdat_q, dat_q;
  logic                   rsp_ack_q, rsp_err_q, rsp_rty_q;
  logic [15:0]            cnt_q;

  // Control / status state
  logic [NUM_BANK-1:0] mmcm_rst_q, bank_rst_q, idelay_act;
  logic [7:0]          pulse_q [NUM_BANK];
  logic [NUM_BANK-1:0] lock_s1, lock_s2, lock_p, rdy_s1, rdy_s2, rdy_p;
  logic [NUM_BANK-1:0] stk_lock, stk_rdy, clr_lock, clr_rdy;
  logic [15:0]         to_cnt;

  logic sel_ack, sel_err, sel_rty, lnk_hit, at_limit, timeout_evt;
  assign sel_ack     = lnk_ack_i[idx_q];
  assign sel_err     = lnk_err_i[idx_q];
  assign sel_rty     = lnk_rty_i[idx_q];
  assign lnk_hit     = sel_ack | sel_err | sel_rty;
  assign at_limit    = (cnt_q == 16'(TIMEOUT - 1));
  assign timeout_evt = (state == S_REMOTE) && wb.wb_cyc_i && !lnk_hit && at_limit;

  // W1C masks; a simultaneous fall wins because set is OR-ed after clear
  assign clr_lock = (lwr && reg_idx == 2'd2 && wb.wb_sel_i[0]) ? wb.wb_dat_i[NUM_BANK-1:0] : '0;
  assign clr_rdy  = (lwr && reg_idx == 2'd2 && wb.wb_sel_i[1]) ? wb.wb_dat_i[8 +: NUM_BANK] : '0;

  always_comb begin
    for (int k = 0; k < NUM_BANK; k++) idelay_act[k] = (pulse_q[k] != 8'd0);
  end

  logic [31:0] local_rdata;
  always_comb begin
    local_rdata = '0;
    case (reg_idx)
      2'd0: begin
        local_rdata[NUM_BANK-1:0]    = mmcm_rst_q;
        local_rdata[8 +: NUM_BANK]   = idelay_act;
        local_rdata[16 +: NUM_BANK]  = bank_rst_q;
      end
      2'd1: begin
        local_rdata[NUM_BANK-1:0]    = lock_s2;
        local_rdata[8 +: NUM_BANK]   = rdy_s2;
      end
      2'd2: begin
        local_rdata[NUM_BANK-1:0]    = stk_lock;
        local_rdata[8 +: NUM_BANK]   = stk_rdy;
      end
      default: local_rdata = {8'(NUM_BANK), 8'(NUM_IF), to_cnt};
    endcase
  end

  // FSM: state register
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state <= S_IDLE;
    else       state <= state_nxt;
  end

  // FSM: next state
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:   if (req) state_nxt = is_link ? S_REMOTE : S_LRESP;
      S_LRESP:  state_nxt = S_IDLE;
      S_REMOTE: begin
        if (!wb.wb_cyc_i)              state_nxt = S_IDLE;
        else if (lnk_hit || at_limit)  state_nxt = S_RRESP;
      end
      default:  state_nxt = S_IDLE;
    endcase
  end

  // FSM: outputs, derived only from registered state
  always_comb begin
    wb.wb_dat_o = '0;
    wb.wb_ack_o = 1'b0;
    wb.wb_err_o = 1'b0;
    wb.wb_rty_o = 1'b0;
    lnk_cyc_o   = '0;
    lnk_stb_o   = '0;
    lnk_we_o    = '0;
    case (state)
      S_LRESP: begin
        wb.wb_ack_o = 1'b1;
        wb.wb_dat_o = dat_q;
      end
      S_REMOTE: begin
        lnk_cyc_o[idx_q] = 1'b1;
        lnk_stb_o[idx_q] = 1'b1;
        lnk_we_o[idx_q]  = we_q;
      end
      S_RRESP: begin
        wb.wb_ack_o = rsp_ack_q;
        wb.wb_err_o = rsp_err_q;
        wb.wb_rty_o = rsp_rty_q;
        wb.wb_dat_o = dat_q;
      end
      default: ;
    endcase
  end

  assign lnk_adr_o    = {NUM_IF{adr_q}};
  assign lnk_dat_o    = wdat_q;
  assign lnk_sel_o    = sel_q;
  assign mmcm_rst_o   = mmcm_rst_q;
  assign bank_rst_o   = bank_rst_q;
  assign idelay_rst_o = idelay_act;
  assign dbg_state    = state;

  // Datapath
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      idx_q <= '0; adr_q <= '0; we_q <= 1'b0; sel_q <= '0;
      wdat_q <= '0; dat_q <= '0; cnt_q <= '0;
      rsp_ack_q <= 1'b0; rsp_err_q <= 1'b0; rsp_rty_q <= 1'b0;
      mmcm_rst_q <= '0; bank_rst_q <= '0;
      for (int k = 0; k < NUM_BANK; k++) pulse_q[k] <= 8'd0;
      lock_s1 <= '0; lock_s2 <= '0; lock_p <= '0;
      rdy_s1 <= '0; rdy_s2 <= '0; rdy_p <= '0;
      stk_lock <= '0; stk_rdy <= '0; to_cnt <= '0;
    end else begin
      if (state == S_IDLE && req) begin
        if (is_link) begin
          idx_q  <= dec_idx;
          adr_q  <= wb.wb_adr_i[SUB_BITS-1:0];
          we_q   <= wb.wb_we_i;
          sel_q  <= wb.wb_sel_i;
          wdat_q <= wb.wb_dat_i;
        end else begin
          dat_q  <= local_rdata;
        end
      end

      if (state == S_REMOTE && wb.wb_cyc_i) begin
        cnt_q <= cnt_q + 16'd1;
        if (lnk_hit) begin
          rsp_ack_q <= sel_ack;
          rsp_err_q <= sel_err;
          rsp_rty_q <= sel_rty;
          dat_q     <= lnk_dat_i[idx_q*32 +: 32];
        end else if (at_limit) begin
          rsp_ack_q <= 1'b0;
          rsp_err_q <= 1'b1;
          rsp_rty_q <= 1'b0;
        end
      end else begin
        cnt_q <= '0;
      end

      if (lwr && reg_idx == 2'd0) begin
        if (wb.wb_sel_i[0]) mmcm_rst_q <= wb.wb_dat_i[NUM_BANK-1:0];
        if (wb.wb_sel_i[2]) bank_rst_q <= wb.wb_dat_i[16 +: NUM_BANK];
      end

      // A new start always reloads the full length, even mid-pulse
      for (int k = 0; k < NUM_BANK; k++) begin
        if (lwr && reg_idx == 2'd0 && wb.wb_sel_i[1] && wb.wb_dat_i[8+k])
          pulse_q[k] <= 8'(RST_PULSE_LEN);
        else if (pulse_q[k] != 8'd0)
          pulse_q[k] <= pulse_q[k] - 8'd1;
      end

      lock_s1 <= mmcm_locked_i; lock_s2 <= lock_s1; lock_p <= lock_s2;
      rdy_s1  <= idelay_rdy_i;  rdy_s2  <= rdy_s1;  rdy_p  <= rdy_s2;
      stk_lock <= (stk_lock & ~clr_lock) | (lock_p & ~lock_s2);
      stk_rdy  <= (stk_rdy  & ~clr_rdy)  | (rdy_p  & ~rdy_s2);

      if (lwr && reg_idx == 2'd3)
        to_cnt <= '0;
      else if (timeout_evt && to_cnt != 16'hFFFF)
        to_cnt <= to_cnt + 16'd1;
    end
  end
endmodule

// File: tb/tb_turfio_hub_ctrl.sv
// tb_turfio_hub_ctrl
// Directed bench for turfio_hub_ctrl (NUM_IF=4, NUM_BANK=2, TIMEOUT=255,
// RST_PULSE_LEN=16). Inputs are driven 1 time unit after the rising edge and
// outputs are sampled at that same point, so a value seen there belongs to the
// cycle that follows the edge.
module tb_turfio_hub_ctrl;
  localparam int NUM_IF   = 4;
  localparam int ADR_BITS = 15;
  localparam int NUM_BANK = 2;
  localparam int SUB_BITS = 12;

  localparam logic [14:0] A_CTRL   = 15'h0000;
  localparam logic [14:0] A_STAT   = 15'h0004;
  localparam logic [14:0] A_STICKY = 15'h0008;
  localparam logic [14:0] A_INFO   = 15'h000C;

  // Clock / reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  turfio_hub_ctrl_if #(.ADR_BITS(ADR_BITS)) wb();

  logic [NUM_IF-1:0]          lnk_cyc, lnk_stb, lnk_we;
  logic [NUM_IF*SUB_BITS-1:0] lnk_adr;
  logic [31:0]                lnk_dat_out;
  logic [3:0]                 lnk_sel;
  logic [NUM_IF*32-1:0]       lnk_dat;
  logic [NUM_IF-1:0]          lnk_ack, lnk_err, lnk_rty;
  logic [NUM_BANK-1:0]        locked, rdy, mmcm_rst, idelay_rst, bank_rst;
  logic [1:0]                 dbg_state;

  int errors = 0;
  int checks = 0;

  turfio_hub_ctrl #(
    .NUM_IF(NUM_IF), .ADR_BITS(ADR_BITS), .NUM_BANK(NUM_BANK),
    .TIMEOUT(255), .RST_PULSE_LEN(16)
  ) dut (
    .clk_i(clk), .rst_i(rst), .wb(wb.slave),
    .lnk_cyc_o(lnk_cyc), .lnk_stb_o(lnk_stb), .lnk_we_o(lnk_we),
    .lnk_adr_o(lnk_adr), .lnk_dat_o(lnk_dat_out), .lnk_sel_o(lnk_sel),
    .lnk_dat_i(lnk_dat), .lnk_ack_i(lnk_ack), .lnk_err_i(lnk_err), .lnk_rty_i(lnk_rty),
    .mmcm_locked_i(locked), .idelay_rdy_i(rdy),
    .mmcm_rst_o(mmcm_rst), .idelay_rst_o(idelay_rst), .bank_rst_o(bank_rst),
    .dbg_state(dbg_state)
  );

  // Driver tasks: every task starts and ends 1 unit after a rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic bus_idle();
    wb.wb_cyc_i = 1'b0; wb.wb_stb_i = 1'b0; wb.wb_we_i = 1'b0;
    wb.wb_adr_i = '0;   wb.wb_dat_i = '0;   wb.wb_sel_i = '0;
  endtask

  task automatic bus_local(input logic we, input logic [14:0] adr,
                           input logic [31:0] dat, input logic [3:0] sel,
                           output logic [31:0] rdata);
    wb.wb_cyc_i = 1'b1; wb.wb_stb_i = 1'b1; wb.wb_we_i = we;
    wb.wb_adr_i = adr;  wb.wb_dat_i = dat;  wb.wb_sel_i = sel;
    tick();
    checks++;
    if (wb.wb_ack_o !== 1'b1) begin
      errors++;
      $display("FAIL local_ack adr=%h: got %b expected 1", adr, wb.wb_ack_o);
    end
    rdata = wb.wb_dat_o;
    bus_idle();
    tick();
  endtask

  task automatic remote_start(input logic we, input logic [14:0] adr,
                              input logic [31:0] dat, input logic [3:0] sel);
    wb.wb_cyc_i = 1'b1; wb.wb_stb_i = 1'b1; wb.wb_we_i = we;
    wb.wb_adr_i = adr;  wb.wb_dat_i = dat;  wb.wb_sel_i = sel;
    tick();
  endtask

  task automatic test_reset();
    logic [31:0] rd;
    repeat (3) tick();
    checks++;
    if ({lnk_cyc, lnk_stb, mmcm_rst, idelay_rst, bank_rst, wb.wb_ack_o, wb.wb_err_o, wb.wb_rty_o} !== '0
        || wb.wb_dat_o !== 32'h0) begin
      errors++;
      $display("FAIL reset_outputs: got cyc=%b mmcm=%b dat=%h expected all zero", lnk_cyc, mmcm_rst, wb.wb_dat_o);
    end
    rst = 1'b0;
    tick();
    bus_local(1'b1, A_CTRL, 32'h0003_0103, 4'hF, rd);
    remote_start(1'b0, 15'h7000, 32'h0, 4'hF);
    checks++;
    if (lnk_cyc !== 4'b1000 || mmcm_rst !== 2'b11) begin
      errors++;
      $display("FAIL reset_pre: got cyc=%b mmcm=%b expected 1000/11", lnk_cyc, mmcm_rst);
    end
    rst = 1'b1;
    #1;
    checks++;
    if ({lnk_cyc, lnk_stb, mmcm_rst, idelay_rst, bank_rst, wb.wb_ack_o, wb.wb_err_o, wb.wb_rty_o} !== '0) begin
      errors++;
      $display("FAIL reset_mid_remote: got cyc=%b mmcm=%b idly=%b bank=%b expected all zero",
               lnk_cyc, mmcm_rst, idelay_rst, bank_rst);
    end
    bus_idle();
    tick();
    rst = 1'b0;
    repeat (5) tick();
    bus_local(1'b0, A_STICKY, 32'h0, 4'hF, rd);
    checks++;
    if (rd !== 32'h0) begin errors++; $display("FAIL reset_sticky: got %h expected 00000000", rd); end
    bus_local(1'b0, A_STAT, 32'h0, 4'hF, rd);
    checks++;
    if (rd !== 32'h0000_0303) begin errors++; $display("FAIL reset_stat: got %h expected 00000303", rd); end
    bus_local(1'b0, A_CTRL, 32'h0, 4'hF, rd);
    checks++;
    if (rd !== 32'h0) begin errors++; $display("FAIL reset_ctrl: got %h expected 00000000", rd); end
    bus_local(1'b0, A_INFO, 32'h0, 4'hF, rd);
    checks++;
    if (rd !== 32'h0204_0000) begin errors++; $display("FAIL reset_info: got %h expected 02040000", rd); end
  endtask

  task automatic test_ctrl();
    logic [31:0] rd;
    int high;
    wb.wb_cyc_i = 1'b1; wb.wb_stb_i = 1'b1; wb.wb_we_i = 1'b1;
    wb.wb_adr_i = A_CTRL; wb.wb_dat_i = 32'h0003_0103; wb.wb_sel_i = 4'hF;
    tick();
    checks++;
    if (wb.wb_ack_o !== 1'b1 || mmcm_rst !== 2'b11 || bank_rst !== 2'b11 || idelay_rst !== 2'b01) begin
      errors++;
      $display("FAIL ctrl_write: got ack=%b mmcm=%b bank=%b idly=%b expected 1/11/11/01",
               wb.wb_ack_o, mmcm_rst, bank_rst, idelay_rst);
    end
    bus_idle();
    high = 0;
    for (int i = 0; i < 40; i++) begin
      if (idelay_rst[0]) high++;
      tick();
    end
    checks++;
    if (high != 16) begin errors++; $display("FAIL ctrl_pulse_len: got %0d expected 16", high); end
    bus_local(1'b0, A_CTRL, 32'h0, 4'hF, rd);
    checks++;
    if (rd !== 32'h0003_0003) begin errors++; $display("FAIL ctrl_read_after: got %h expected 00030003", rd); end
    bus_local(1'b1, A_CTRL, 32'h0003_0103, 4'hF, rd);
    bus_local(1'b0, A_CTRL, 32'h0, 4'hF, rd);
    checks++;
    if (rd !== 32'h0003_0103) begin errors++; $display("FAIL ctrl_read_during: got %h expected 00030103", rd); end
    // Only byte 0 selected: mmcm cleared, bank reset kept, pulse still running
    bus_local(1'b1, A_CTRL, 32'h0000_0000, 4'b0001, rd);
    bus_local(1'b0, A_CTRL, 32'h0, 4'hF, rd);
    checks++;
    if (rd !== 32'h0003_0100 || mmcm_rst !== 2'b00 || bank_rst !== 2'b11) begin
      errors++;
      $display("FAIL ctrl_sel_mask: got %h mmcm=%b bank=%b expected 00030100/00/11", rd, mmcm_rst, bank_rst);
    end
    bus_local(1'b1, A_CTRL, 32'h0, 4'hF, rd);
    repeat (20) tick();
  endtask

  task automatic test_routing();
    int early;
    int acks;
    lnk_dat = {32'hDEAD_BEEF, 32'hDEAD_BEEF, 32'h2222_2222, 32'h1111_1111};
    lnk_dat[2*32 +: 32] = 32'hDEAD_BEEF;
    lnk_dat[3*32 +: 32] = 32'h3333_3333;
    remote_start(1'b0, 15'h6004, 32'h0, 4'hF);
    checks++;
    if (lnk_cyc !== 4'b0100 || lnk_stb !== 4'b0100 || lnk_we !== 4'b0000 ||
        lnk_adr[2*SUB_BITS +: SUB_BITS] !== 12'h004) begin
      errors++;
      $display("FAIL route_strobes: got cyc=%b stb=%b we=%b adr=%h expected 0100/0100/0000/004",
               lnk_cyc, lnk_stb, lnk_we, lnk_adr[2*SUB_BITS +: SUB_BITS]);
    end
    early = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (wb.wb_ack_o || lnk_cyc !== 4'b0100) early++;
    end
    checks++;
    if (early != 0) begin errors++; $display("FAIL route_wait: got %0d bad cycles expected 0", early); end
    lnk_ack[2] = 1'b1;
    tick();
    lnk_ack = '0;
    checks++;
    if (wb.wb_ack_o !== 1'b1 || wb.wb_dat_o !== 32'hDEAD_BEEF || lnk_cyc !== 4'b0000 || wb.wb_err_o !== 1'b0) begin
      errors++;
      $display("FAIL route_resp: got ack=%b dat=%h cyc=%b expected 1/deadbeef/0000", wb.wb_ack_o, wb.wb_dat_o, lnk_cyc);
    end
    bus_idle();
    acks = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (wb.wb_ack_o) acks++;
    end
    checks++;
    if (acks != 0) begin errors++; $display("FAIL route_single_ack: got %0d extra acks expected 0", acks); end
  endtask

  task automatic test_link_write();
    remote_start(1'b1, 15'h4008, 32'h1234_5678, 4'b0011);
    checks++;
    if (lnk_we !== 4'b0001 || lnk_dat_out !== 32'h1234_5678 || lnk_sel !== 4'b0011 ||
        lnk_adr[0 +: SUB_BITS] !== 12'h008) begin
      errors++;
      $display("FAIL wr_fields: got we=%b dat=%h sel=%b adr=%h expected 0001/12345678/0011/008",
               lnk_we, lnk_dat_out, lnk_sel, lnk_adr[0 +: SUB_BITS]);
    end
    lnk_ack[0] = 1'b1;
    tick();
    lnk_ack = '0;
    checks++;
    if (wb.wb_ack_o !== 1'b1) begin errors++; $display("FAIL wr_min_latency: got ack=%b expected 1", wb.wb_ack_o); end
    bus_idle();
    tick();
    // Response from an unselected link must be ignored, then rty from link 1
    remote_start(1'b0, 15'h5ABC, 32'h0, 4'hF);
    lnk_ack[0] = 1'b1;
    tick();
    lnk_ack = '0;
    checks++;
    if (lnk_cyc !== 4'b0010 || wb.wb_ack_o !== 1'b0) begin
      errors++;
      $display("FAIL other_link_ignored: got cyc=%b ack=%b expected 0010/0", lnk_cyc, wb.wb_ack_o);
    end
    lnk_rty[1] = 1'b1;
    tick();
    lnk_rty = '0;
    checks++;
    if (wb.wb_rty_o !== 1'b1 || wb.wb_ack_o !== 1'b0 || wb.wb_err_o !== 1'b0) begin
      errors++;
      $display("FAIL rty_resp: got rty=%b ack=%b err=%b expected 1/0/0", wb.wb_rty_o, wb.wb_ack_o, wb.wb_err_o);
    end
    bus_idle();
    tick();
  endtask

  task automatic test_timeout();
    logic [31:0] rd;
    int n;
    logic got;
    for (int r = 0; r < 3; r++) begin
      remote_start(1'b0, 15'h7FFC, 32'h0, 4'hF);
      n = 0;
      got = 1'b0;
      for (int i = 0; i < 400; i++) begin
        if (lnk_stb[3]) n++;
        if (wb.wb_err_o) begin got = 1'b1; break; end
        tick();
      end
      checks++;
      if (!got || n != 255) begin
        errors++;
        $display("FAIL timeout_len run %0d: got err=%b strobes=%0d expected 1/255", r, got, n);
      end
      bus_idle();
      tick();
      if (r == 0) begin
        bus_local(1'b0, A_INFO, 32'h0, 4'hF, rd);
        checks++;
        if (rd !== 32'h0204_0001) begin errors++; $display("FAIL info_one: got %h expected 02040001", rd); end
      end
    end
    bus_local(1'b0, A_INFO, 32'h0, 4'hF, rd);
    checks++;
    if (rd !== 32'h0204_0003) begin errors++; $display("FAIL info_three: got %h expected 02040003", rd); end
    bus_local(1'b1, A_INFO, 32'hFFFF_FFFF, 4'hF, rd);
    bus_local(1'b0, A_INFO, 32'h0, 4'hF, rd);
    checks++;
    if (rd !== 32'h0204_0000) begin errors++; $display("FAIL info_clear: got %h expected 02040000", rd); end
  endtask

  task automatic test_abort();
    logic [31:0] rd;
    int resp;
    remote_start(1'b0, 15'h5000, 32'h0, 4'hF);
    repeat (250) tick();
    bus_idle();
    tick();
    checks++;
    if (lnk_cyc !== 4'b0000 || lnk_stb !== 4'b0000 || wb.wb_ack_o || wb.wb_err_o) begin
      errors++;
      $display("FAIL abort_drop: got cyc=%b stb=%b ack=%b err=%b expected 0000/0000/0/0",
               lnk_cyc, lnk_stb, wb.wb_ack_o, wb.wb_err_o);
    end
    resp = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (wb.wb_ack_o || wb.wb_err_o || wb.wb_rty_o) resp++;
    end
    checks++;
    if (resp != 0) begin errors++; $display("FAIL abort_no_resp: got %0d responses expected 0", resp); end
    bus_local(1'b0, A_INFO, 32'h0, 4'hF, rd);
    checks++;
    if (rd !== 32'h0204_0000) begin errors++; $display("FAIL abort_info: got %h expected 02040000", rd); end
  endtask

  task automatic test_sticky();
    logic [31:0] rd;
    locked[1] = 1'b0;
    tick();
    locked[1] = 1'b1;
    repeat (4) tick();
    bus_local(1'b0, A_STICKY, 32'h0, 4'hF, rd);
    checks++;
    if (rd !== 32'h0000_0002) begin errors++; $display("FAIL sticky_set: got %h expected 00000002", rd); end
    bus_local(1'b1, A_STICKY, 32'h0000_0002, 4'hF, rd);
    bus_local(1'b0, A_STICKY, 32'h0, 4'hF, rd);
    checks++;
    if (rd !== 32'h0) begin errors++; $display("FAIL sticky_clear: got %h expected 00000000", rd); end
    // Fall is registered two edges after the dropped sample; the W1C lands on that edge
    locked[1] = 1'b0;
    tick();
    locked[1] = 1'b1;
    tick();
    bus_local(1'b1, A_STICKY, 32'h0000_0002, 4'hF, rd);
    bus_local(1'b0, A_STICKY, 32'h0, 4'hF, rd);
    checks++;
    if (rd !== 32'h0000_0002) begin errors++; $display("FAIL sticky_set_wins: got %h expected 00000002", rd); end
    rdy[0] = 1'b0;
    tick();
    rdy[0] = 1'b1;
    repeat (4) tick();
    bus_local(1'b0, A_STICKY, 32'h0, 4'hF, rd);
    checks++;
    if (rd !== 32'h0000_0102) begin errors++; $display("FAIL sticky_rdy: got %h expected 00000102", rd); end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus_idle();
    lnk_dat = '0; lnk_ack = '0; lnk_err = '0; lnk_rty = '0;
    locked = 2'b11; rdy = 2'b11;
    #1;
    test_reset();
    test_ctrl();
    test_routing();
    test_link_write();
    test_timeout();
    test_abort();
    test_sticky();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
